// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep capture unit.
//   tt_state_t    : controller states
//   TT_MAX_SETTLE : largest supported per-vector settle wait
//   tt_depth(n)   : truth-table depth for n inputs (2^n)
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } tt_state_t;

  localparam int TT_MAX_SETTLE = 15;

  function automatic int tt_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_counter.sv
// Vector / wait counter pair for the sweep.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart at vector 0, wait 0
//   enable     : sweep in progress
//   settle     : wait cycles per vector before sampling
//   vec        : vector currently applied
//   sample     : strobe, function output is to be captured this edge
//   last       : vec is the final vector
module tt_sweep_counter #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [3:0]      settle,
  output logic [N_IN-1:0] vec,
  output logic            sample,
  output logic            last
);

  logic [3:0] wcnt;

  assign sample = enable && (wcnt == settle);
  assign last   = &vec;

  // On the final sample vec wraps to 0, so it reads 0 in REPORT/IDLE
  // without any extra clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec  <= '0;
      wcnt <= '0;
    end else if (clear) begin
      vec  <= '0;
      wcnt <= '0;
    end else if (sample) begin
      vec  <= vec + 1'b1;
      wcnt <= '0;
    end else if (enable) begin
      wcnt <= wcnt + 4'd1;
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table capture: sweeps all 2^N_IN vectors onto vec_out, samples
// fn_in after SETTLE+1 cycles per vector, and reports the table, its
// population count and constant flags through a valid/ready handshake.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a sweep (IDLE only)
//   vec_out      : vector applied to the function (msb = a)
//   fn_in        : function output
//   busy         : high in RUN and REPORT
//   table_out    : bit k = f(k)
//   ones_count   : number of 1 entries
//   is_const0/1  : function is constant 0 / 1
//   result_valid : result held in REPORT
//   result_ready : consumer accepts result
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [N_IN-1:0]           vec_out,
  input  logic                      fn_in,
  output logic                      busy,
  output logic [tt_depth(N_IN)-1:0] table_out,
  output logic [N_IN:0]             ones_count,
  output logic                      is_const0,
  output logic                      is_const1,
  output logic                      result_valid,
  input  logic                      result_ready
);

  localparam int DEPTH = tt_depth(N_IN);
  // Out-of-range settle values saturate rather than alias.
  localparam logic [3:0] SETTLE_W =
    (SETTLE > TT_MAX_SETTLE) ? 4'(TT_MAX_SETTLE) : 4'(SETTLE);

  tt_state_t state_q, state_d;
  logic      go, sample, last;

  assign go = (state_q == IDLE) && start;

  tt_sweep_counter #(.N_IN(N_IN)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (go),
    .enable (state_q == RUN),
    .settle (SETTLE_W),
    .vec    (vec_out),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)          state_d = RUN;
      RUN:     if (sample && last) state_d = REPORT;
      REPORT:  if (result_ready)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Table and count are only written on a start or a sample strobe, so
  // they stay frozen through REPORT and the following IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_out  <= '0;
      ones_count <= '0;
    end else if (go) begin
      table_out  <= '0;
      ones_count <= '0;
    end else if (sample) begin
      table_out[vec_out] <= fn_in;
      ones_count         <= ones_count + {{N_IN{1'b0}}, fn_in};
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == REPORT);
  assign is_const0    = (ones_count == '0);
  assign is_const1    = (ones_count == (N_IN+1)'(DEPTH));

endmodule

// File: tb/tb_tt_sweep_capture.sv
module tb_tt_sweep_capture;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic        c0;
    logic        c1;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: SETTLE=0, combinational function selected by mode
  logic        start0 = 1'b0, ready0 = 1'b1, fn0;
  logic [3:0]  vec0;
  logic        busy0, c00, c10, rv0;
  logic [15:0] tbl0;
  logic [4:0]  ones0;
  int          mode = 0;

  // dut2: SETTLE=2, function is vec[3] through two registers
  logic        start2 = 1'b0, ready2 = 1'b1, fn2;
  logic [3:0]  vec2;
  logic        busy2, c02, c12, rv2;
  logic [15:0] tbl2;
  logic [4:0]  ones2;
  logic        dly1 = 1'b0, dly2 = 1'b0;

  always_comb begin
    fn0 = 1'b0;
    case (mode)
      0: fn0 = (vec0[3] | vec0[2] | vec0[1] | vec0[0]) & ~(vec0[3] | vec0[2] | vec0[1] | vec0[0])
               & (vec0[3] | vec0[2] | vec0[1] | ~vec0[0]);
      1: fn0 = vec0[0];
      2: fn0 = &vec0;
      3: fn0 = |vec0;
      4: fn0 = 1'b1;
      default: fn0 = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    dly1 <= vec2[3];
    dly2 <= dly1;
  end
  assign fn2 = dly2;

  tt_sweep_capture #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0), .fn_in(fn0),
    .busy(busy0), .table_out(tbl0), .ones_count(ones0), .is_const0(c00),
    .is_const1(c10), .result_valid(rv0), .result_ready(ready0));

  tt_sweep_capture #(.N_IN(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec2), .fn_in(fn2),
    .busy(busy2), .table_out(tbl2), .ones_count(ones2), .is_const0(c02),
    .is_const1(c12), .result_valid(rv2), .result_ready(ready2));

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   st[2];
  bit   seen[2];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic score(input int id, input logic s, input logic b, input logic rv,
                       input logic rdy, input logic [15:0] t, input logic [4:0] o,
                       input logic k0, input logic k1);
    exp_t e;
    int   n;
    if (rst_n && s && !b) st[id] = cyc + 1;
    n = (id == 0) ? q0.size() : q1.size();
    if (rv && !seen[id]) begin
      if (n == 0) chk($sformatf("unexpected_result%0d", id), 1, 0);
      else begin
        e = (id == 0) ? q0[0] : q1[0];
        chk($sformatf("latency%0d", id), cyc - st[id], e.lat);
      end
    end
    seen[id] = rv;
    if (rv && rdy && n != 0) begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      chk($sformatf("table%0d", id), t, e.tbl);
      chk($sformatf("ones%0d", id), o, e.ones);
      chk($sformatf("const0_%0d", id), k0, e.c0);
      chk($sformatf("const1_%0d", id), k1, e.c1);
      chk($sformatf("busy_in_report%0d", id), b, 1);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #1;
      score(0, start0, busy0, rv0, ready0, tbl0, ones0, c00, c10);
      score(1, start2, busy2, rv2, ready2, tbl2, ones2, c02, c12);
    end
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 200) begin @(negedge clk); n++; end
    chk("sweep_done0", busy0, 0);
  endtask

  task automatic run0(input int m, input logic [15:0] t, input int o,
                      input logic k0, input logic k1);
    exp_t e;
    e.tbl = t; e.ones = 5'(o); e.c0 = k0; e.c1 = k1; e.lat = 16;
    q0.push_back(e);
    @(negedge clk);
    mode = m; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0();
  endtask

  initial begin
    exp_t e;
    int   n;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_vec", vec0, 0);
    chk("rst_table", tbl0, 0);
    chk("rst_ones", ones0, 0);
    chk("rst_valid", rv0, 0);
    chk("rst_const1", c10, 0);
    chk("rst_const0", c00, 1);
    rst_n = 1'b1;

    run0(0, 16'h0000, 0,  1'b1, 1'b0);
    run0(1, 16'hAAAA, 8,  1'b0, 1'b0);
    run0(2, 16'h8000, 1,  1'b0, 1'b0);
    run0(3, 16'hFFFE, 15, 1'b0, 1'b0);
    run0(4, 16'hFFFF, 16, 1'b0, 1'b1);
    chk("idle_table_held", tbl0, 16'hFFFF);

    // SETTLE=2 with a two-register delayed function
    e.tbl = 16'hFF00; e.ones = 5'd8; e.c0 = 1'b0; e.c1 = 1'b0; e.lat = 48;
    q1.push_back(e);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (busy2 && n < 300) begin @(negedge clk); n++; end
    chk("sweep_done2", busy2, 0);

    // back-pressure: ready low in REPORT, start pulses ignored
    e.tbl = 16'hAAAA; e.ones = 5'd8; e.c0 = 1'b0; e.c1 = 1'b0; e.lat = 16;
    q0.push_back(e);
    @(negedge clk); ready0 = 1'b0; mode = 1; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (!rv0 && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid", rv0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start0 = (i % 2 == 0);
      chk("bp_busy", busy0, 1);
      chk("bp_valid_hold", rv0, 1);
      chk("bp_table", tbl0, 16'hAAAA);
      chk("bp_ones", ones0, 8);
      chk("bp_vec", vec0, 0);
    end
    @(negedge clk); start0 = 1'b0; ready0 = 1'b1;
    @(negedge clk);
    chk("bp_idle", busy0, 0);
    chk("bp_valid_drop", rv0, 0);
    @(negedge clk);
    chk("bp_start_ignored", busy0, 0);

    // reset mid-sweep at vector 7
    @(negedge clk); mode = 1; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (vec0 != 4'd7 && n < 50) begin @(negedge clk); n++; end
    chk("reached_vec7", vec0, 7);
    chk("partial_table", tbl0, 16'h002A);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy0, 0);
    chk("midrst_table", tbl0, 0);
    chk("midrst_vec", vec0, 0);
    chk("midrst_ones", ones0, 0);
    chk("midrst_const0", c00, 1);
    rst_n = 1'b1;
    run0(3, 16'hFFFE, 15, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
